// File: rtl/stack_program_sequencer.sv
// rtl/stack_program_sequencer.sv - nibble program store that replays opcodes/operands onto the stack CPU bus
module stack_program_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [3:0]    load_data,
    input  logic          load_clr,
    input  logic          run,
    output logic          cpu_rst,
    output logic [3:0]    cpu_nibble,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic [AW-1:0] pc
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, CPURST, FETCH, EXEC, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] len_q, len_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [3:0]    mem_q [DEPTH];
    logic          mem_we;

    logic [3:0]    opcode;
    logic [3:0]    operand;
    logic [AW-1:0] pc_plus1;
    logic [AW:0]   pc_wide;
    logic [AW-1:0] pc_next;
    logic          is_long;
    logic          is_push;

    // pc never equals prog_len in FETCH/EXEC, so the truncated index is always in range
    assign opcode   = mem_q[pc_q[IW-1:0]];
    assign pc_plus1 = pc_q + AW'(1);
    assign operand  = (pc_plus1 >= len_q) ? 4'h0 : mem_q[pc_plus1[IW-1:0]];
    assign is_push  = (opcode == 4'h1);
    assign pc_wide  = {1'b0, pc_q} + (is_push ? (AW+1)'(2) : (AW+1)'(1));
    assign pc_next  = (pc_wide > {1'b0, len_q}) ? len_q : pc_wide[AW-1:0];

    always_comb begin
        case (opcode)
            4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: is_long = 1'b1;
            default:                                          is_long = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (run) begin
                    state_d = CPURST;
                    pc_d    = '0;
                end else if (load_clr) begin
                    len_d   = '0;
                    state_d = IDLE;
                end else if (load_en) begin
                    state_d = IDLE;
                    if (!full) begin
                        mem_we = 1'b1;
                        len_d  = len_q + AW'(1);
                    end
                end
            end
            CPURST: state_d = (len_q == '0) ? DONE : FETCH;
            FETCH: begin
                if (opcode == 4'hF) begin
                    state_d = DONE;
                end else begin
                    state_d = EXEC;
                    cnt_d   = is_long ? 2'd2 : 2'd1;
                end
            end
            EXEC: begin
                if (cnt_q <= 2'd1) begin
                    pc_d    = pc_next;
                    state_d = (pc_next >= len_q) ? DONE : FETCH;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[len_q[IW-1:0]] <= load_data;
    end

    always_comb begin
        cpu_nibble = 4'h0;
        if (state_q == FETCH)                cpu_nibble = opcode;
        else if (state_q == EXEC && is_push) cpu_nibble = operand;
    end

    assign cpu_rst = rst | (state_q == CPURST);
    assign busy    = (state_q == CPURST) || (state_q == FETCH) || (state_q == EXEC);
    assign done    = (state_q == DONE);
    assign full    = (len_q == AW'(DEPTH));
    assign pc      = pc_q;
endmodule

// File: tb/tb_stack_program_sequencer.sv
// tb/tb_stack_program_sequencer.sv - directed self-checking bench for stack_program_sequencer
module tb_stack_program_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [3:0] load_data;
    logic       load_clr;
    logic       run;
    logic       cpu_rst;
    logic [3:0] cpu_nibble;
    logic       busy;
    logic       done;
    logic       full;
    logic [4:0] pc;

    int vectors = 0;
    int errors  = 0;

    stack_program_sequencer #(.DEPTH(16), .AW(5)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
        .load_clr(load_clr), .run(run), .cpu_rst(cpu_rst), .cpu_nibble(cpu_nibble),
        .busy(busy), .done(done), .full(full), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic load_nib(input logic [3:0] d);
        load_en = 1'b1; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clr_prog();
        load_clr = 1'b1;
        @(negedge clk);
        load_clr = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic load_main();
        logic [3:0] p [6];
        p = '{4'h1, 4'h3, 4'h1, 4'h4, 4'hA, 4'h3};
        clr_prog();
        for (int i = 0; i < 6; i++) load_nib(p[i]);
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b exp 1", cpu_rst); end
        vectors++; if ({busy, done, full} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, full}); end
        vectors++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
        vectors++; if (cpu_nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble got %h exp 0", cpu_nibble); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL release_cpu_rst got %b exp 0", cpu_rst); end
    endtask

    task automatic test_program();
        logic [3:0] e [12];
        e = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h1, 4'h4, 4'h4, 4'hA, 4'h0, 4'h0, 4'h3, 4'h0};
        load_main();
        pulse_run();
        vectors++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL prog_cpurst got rst=%b busy=%b exp 1 1", cpu_rst, busy); end
        for (int i = 0; i < 12; i++) begin
            vectors++; if (cpu_nibble !== e[i] || done !== 1'b0) begin errors++; $display("FAIL prog_nibble[%0d] got %h done=%b exp %h done=0", i, cpu_nibble, done, e[i]); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL prog_done got done=%b busy=%b exp 1 0", done, busy); end
        vectors++; if (pc !== 5'd6) begin errors++; $display("FAIL prog_pc got %0d exp 6", pc); end
    endtask

    task automatic test_halt();
        logic [3:0] e [5];
        e = '{4'h0, 4'h7, 4'h0, 4'h0, 4'hF};
        clr_prog();
        load_nib(4'h7); load_nib(4'hF); load_nib(4'h2);
        pulse_run();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (cpu_nibble !== e[i]) begin errors++; $display("FAIL halt_nibble[%0d] got %h exp %h", i, cpu_nibble, e[i]); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || pc !== 5'd1) begin errors++; $display("FAIL halt_done got done=%b pc=%0d exp 1 1", done, pc); end
    endtask

    task automatic test_trailing_push();
        logic [3:0] e [4];
        e = '{4'h0, 4'h1, 4'h0, 4'h0};
        clr_prog();
        load_nib(4'h1);
        pulse_run();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (cpu_nibble !== e[i] || done !== 1'b0) begin errors++; $display("FAIL tpush_nibble[%0d] got %h done=%b exp %h done=0", i, cpu_nibble, done, e[i]); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || pc !== 5'd1) begin errors++; $display("FAIL tpush_done got done=%b pc=%0d exp 1 1", done, pc); end
    endtask

    task automatic test_capacity();
        clr_prog();
        for (int i = 0; i < 15; i++) load_nib(4'h0);
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL cap_15 got full=%b exp 0", full); end
        load_nib(4'h0);
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL cap_16 got full=%b exp 1", full); end
        load_nib(4'hF);
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL cap_17 got full=%b exp 1", full); end
        pulse_run();
        for (int i = 1; i < 33; i++) @(negedge clk);
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL cap_early got done=%b exp 0", done); end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || pc !== 5'd16) begin errors++; $display("FAIL cap_done got done=%b pc=%0d exp 1 16", done, pc); end
    endtask

    task automatic test_empty();
        clr_prog();
        pulse_run();
        vectors++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL empty_cpurst got rst=%b busy=%b exp 1 1", cpu_rst, busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b1 || pc !== 5'd0 || cpu_rst !== 1'b0) begin errors++; $display("FAIL empty_done got done=%b pc=%0d rst=%b exp 1 0 0", done, pc, cpu_rst); end
    endtask

    task automatic test_busy_cmds();
        logic [3:0] e [12];
        e = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h1, 4'h4, 4'h4, 4'hA, 4'h0, 4'h0, 4'h3, 4'h0};
        load_main();
        pulse_run();
        for (int i = 0; i < 12; i++) begin
            vectors++; if (cpu_nibble !== e[i]) begin errors++; $display("FAIL busy_nibble[%0d] got %h exp %h", i, cpu_nibble, e[i]); end
            run = (i < 11); load_en = (i < 11); load_data = 4'hF;
            @(negedge clk);
        end
        run = 1'b0; load_en = 1'b0;
        vectors++; if (done !== 1'b1 || pc !== 5'd6) begin errors++; $display("FAIL busy_done got done=%b pc=%0d exp 1 6", done, pc); end
        pulse_run();
        for (int i = 0; i < 12; i++) @(negedge clk);
        vectors++; if (done !== 1'b1 || pc !== 5'd6) begin errors++; $display("FAIL busy_rerun got done=%b pc=%0d exp 1 6", done, pc); end
    endtask

    task automatic test_run_vs_load();
        clr_prog();
        load_nib(4'h3);
        run = 1'b1; load_en = 1'b1; load_data = 4'h1;
        @(negedge clk);
        run = 1'b0; load_en = 1'b0;
        vectors++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL rvl_cpurst got %b exp 1", cpu_rst); end
        @(negedge clk);
        vectors++; if (cpu_nibble !== 4'h3) begin errors++; $display("FAIL rvl_fetch got %h exp 3", cpu_nibble); end
        @(negedge clk); @(negedge clk);
        vectors++; if (done !== 1'b1 || pc !== 5'd1) begin errors++; $display("FAIL rvl_done got done=%b pc=%0d exp 1 1", done, pc); end
    endtask

    task automatic test_rst_mid_exec();
        clr_prog();
        load_nib(4'h1); load_nib(4'h5);
        pulse_run();
        @(negedge clk); @(negedge clk);
        vectors++; if (cpu_nibble !== 4'h5) begin errors++; $display("FAIL rme_operand got %h exp 5", cpu_nibble); end
        #2 rst = 1'b1; #1;
        vectors++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rme_async got rst=%b busy=%b done=%b exp 1 0 0", cpu_rst, busy, done); end
        vectors++; if (pc !== 5'd0 || cpu_nibble !== 4'h0) begin errors++; $display("FAIL rme_pc got pc=%0d nib=%h exp 0 0", pc, cpu_nibble); end
        @(negedge clk); rst = 1'b0;
        pulse_run();
        @(negedge clk);
        vectors++; if (done !== 1'b1 || pc !== 5'd0) begin errors++; $display("FAIL rme_lost got done=%b pc=%0d exp 1 0", done, pc); end
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_data = 4'h0; load_clr = 1'b0; run = 1'b0;
        test_reset();
        test_program();
        test_halt();
        test_trailing_push();
        test_capacity();
        test_empty();
        test_busy_cmds();
        test_run_vs_load();
        test_rst_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
